// File: rtl/led_seq_pkg.sv
// Shared encodings and duty limits for the LED fade sequencer.
package led_seq_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UP      = 3'd1,
    HOLD_HI = 3'd2,
    DOWN    = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  localparam logic [7:0] DUTY_MAX = 8'd255;
  localparam logic [7:0] DUTY_MIN = 8'd0;
endpackage

// File: rtl/led_fade_sequencer_tick_prescaler.sv
// Free-running step-tick divider; tick marks the last count of each period.
module tick_prescaler #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] pcnt;

  assign tick = (pcnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      pcnt <= '0;
    else if (clr) pcnt <= '0;
    else if (en)  pcnt <= tick ? '0 : pcnt + 1'b1;
  end
endmodule

// File: rtl/led_fade_sequencer.sv
// Breathing-pattern duty sequencer: ramp up, hold high, ramp down, hold low.
module led_fade_sequencer
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV   = 1000,
  parameter int STEP       = 1,
  parameter int HOLD_TICKS = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  output logic [7:0] duty,
  output logic       busy,
  output logic [2:0] phase,
  output logic       done,
  output logic [7:0] cycles
);
  localparam int HW = $clog2(HOLD_TICKS) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [8:0] STEP9 = 9'(STEP);

  state_t        state, state_n;
  logic [HW-1:0] hcnt;
  logic          stop_pend, stop_any, tick, hold_done;
  logic [8:0]    up_sum, dn_dif;
  logic [7:0]    duty_up, duty_dn, duty_n;
  logic          hold_clr, hold_inc, cyc_inc;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (state != IDLE),
    .clr  (state == IDLE),
    .tick (tick)
  );

  // 9-bit arithmetic so the carry/borrow bit drives saturation
  assign up_sum    = {1'b0, duty} + STEP9;
  assign dn_dif    = {1'b0, duty} - STEP9;
  assign duty_up   = up_sum[8] ? DUTY_MAX : up_sum[7:0];
  assign duty_dn   = dn_dif[8] ? DUTY_MIN : dn_dif[7:0];
  assign stop_any  = stop | stop_pend;
  assign hold_done = tick && (hcnt == HOLD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start && !stop) state_n = UP;
      UP:      if (stop) state_n = DOWN;
               else if (tick && duty_up == DUTY_MAX) state_n = HOLD_HI;
      HOLD_HI: if (stop || hold_done) state_n = DOWN;
      DOWN:    if (tick && duty_dn == DUTY_MIN)
                 state_n = (loop && !stop_any) ? HOLD_LO : IDLE;
      HOLD_LO: if (stop) state_n = DOWN;
               else if (hold_done) state_n = UP;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    duty_n   = duty;
    hold_clr = (state_n != state);
    hold_inc = 1'b0;
    cyc_inc  = 1'b0;
    case (state)
      IDLE:    duty_n = DUTY_MIN;
      UP:      if (!stop && tick) duty_n = duty_up;
      HOLD_HI, HOLD_LO: hold_inc = tick;
      DOWN: if (tick) begin
        duty_n  = duty_dn;
        // a fade entered at 0 (stop during HOLD_LO) was already counted
        cyc_inc = (duty_dn == DUTY_MIN) && (duty != DUTY_MIN);
      end
      default: duty_n = DUTY_MIN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty      <= DUTY_MIN;
      hcnt      <= '0;
      stop_pend <= 1'b0;
      done      <= 1'b0;
      cycles    <= '0;
    end else begin
      duty <= duty_n;
      if (hold_clr)      hcnt <= '0;
      else if (hold_inc) hcnt <= hcnt + 1'b1;
      if (state_n == IDLE)           stop_pend <= 1'b0;
      else if (stop && state != IDLE) stop_pend <= 1'b1;
      done   <= (state != IDLE) && (state_n == IDLE);
      cycles <= cycles + 8'(cyc_inc);
    end
  end

  assign busy  = (state != IDLE);
  assign phase = state;
endmodule

// File: tb/tb_led_fade_sequencer.sv
// Self-checking bench: IDLE vector table, duty scoreboard, multi-cycle corner sequences.
module tb_led_fade_sequencer;
  import led_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic [7:0] duty0, duty1, duty2, cycles0, cycles1, cycles2;
  logic [2:0] phase0, phase1, phase2;
  logic busy0, busy1, busy2, done0, done1, done2;

  led_fade_sequencer #(.TICK_DIV(4), .STEP(64), .HOLD_TICKS(2)) dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
    .duty(duty0), .busy(busy0), .phase(phase0), .done(done0), .cycles(cycles0));
  led_fade_sequencer #(.TICK_DIV(4), .STEP(1), .HOLD_TICKS(2)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
    .duty(duty1), .busy(busy1), .phase(phase1), .done(done1), .cycles(cycles1));
  led_fade_sequencer #(.TICK_DIV(4), .STEP(255), .HOLD_TICKS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
    .duty(duty2), .busy(busy2), .phase(phase2), .done(done2), .cycles(cycles2));

  always #5 clk = ~clk;

  int checks = 0, failures = 0, done_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] prev0 = 8'd0;
  bit mon_en = 1'b0;

  typedef struct {
    logic       st;
    logic       sp;
    logic [2:0] ph;
    logic       bz;
    logic [7:0] dt;
  } vec_t;
  vec_t vt[4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // every change of dut0 duty must match the next queued value
  always @(negedge clk) begin
    if (done0) done_cnt <= done_cnt + 1;
    if (mon_en && duty0 !== prev0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=%0d expected=none", duty0);
      end else check("sb_duty", duty0, exp_q.pop_front());
    end
    prev0 <= duty0;
  end

  task automatic push_seq64();
    logic [7:0] s [8] = '{8'd64, 8'd128, 8'd192, 8'd255, 8'd191, 8'd127, 8'd63, 8'd0};
    for (int i = 0; i < 8; i++) exp_q.push_back(s[i]);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    exp_q.delete();
    @(negedge clk); #1 mon_en = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  task automatic wait_duty0(input logic [7:0] v, input int bound);
    int n = 0;
    while (duty0 !== v && n < bound) begin @(negedge clk); n++; end
    check("wait_duty", duty0, v);
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done0 !== 1'b1 && n < bound) begin @(negedge clk); n++; end
    check("done_seen", done0, 1);
    check("done_phase", phase0, IDLE);
    check("done_duty", duty0, 0);
    @(negedge clk);
    check("done_one_cycle", done0, 0);
    check("done_busy", busy0, 0);
  endtask

  initial begin
    int n, m, d0, prev1, bad, n255, ndone1;
    bit up;

    vt[0] = '{st: 1'b0, sp: 1'b0, ph: IDLE, bz: 1'b0, dt: 8'd0};
    vt[1] = '{st: 1'b1, sp: 1'b1, ph: IDLE, bz: 1'b0, dt: 8'd0};
    vt[2] = '{st: 1'b0, sp: 1'b1, ph: IDLE, bz: 1'b0, dt: 8'd0};
    vt[3] = '{st: 1'b1, sp: 1'b0, ph: UP,   bz: 1'b1, dt: 8'd0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_duty", duty0, 0);
    check("rst_busy", busy0, 0);
    check("rst_phase", phase0, 0);
    check("rst_done", done0, 0);
    check("rst_cycles", cycles0, 0);

    // single-edge responses from IDLE
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); start = vt[i].st; stop = vt[i].sp;
      @(negedge clk); start = 1'b0; stop = 1'b0;
      check("vec_phase", phase0, vt[i].ph);
      check("vec_busy", busy0, vt[i].bz);
      check("vec_duty", duty0, vt[i].dt);
      do_reset();
    end

    // single fade, start latency and hold length
    loop = 1'b0;
    push_seq64();
    pulse_start();
    check("start_phase", phase0, UP);
    n = 0;
    while (duty0 === 8'd0 && n < 20) begin @(negedge clk); n++; end
    check("start_latency", n, 4);
    wait_duty0(8'd255, 100);
    m = 0;
    while (duty0 === 8'd255 && m < 50) begin @(negedge clk); m++; end
    check("hold_hi_len", m, 12);
    wait_done(200);
    check("fade_cycles", cycles0, 1);
    check("sb_empty", exp_q.size(), 0);

    // three looped fades, then stop in HOLD_LO at duty 0
    do_reset();
    loop = 1'b1;
    d0 = done_cnt;
    for (int k = 0; k < 3; k++) push_seq64();
    pulse_start();
    for (int k = 1; k <= 3; k++) begin
      wait_duty0(8'd255, 100);
      wait_duty0(8'd0, 100);
      check("loop_cycles", cycles0, k);
      check("loop_busy", busy0, 1);
      check("loop_phase", phase0, HOLD_LO);
    end
    check("loop_no_done", done_cnt, d0);
    pulse_stop();
    check("stop_lo_phase", phase0, DOWN);
    check("stop_lo_duty", duty0, 0);
    wait_done(100);
    check("stop_lo_cycles", cycles0, 3);
    check("stop_lo_done_cnt", done_cnt, d0 + 1);
    check("sb_empty", exp_q.size(), 0);
    loop = 1'b0;

    // stop during UP at 128
    do_reset();
    exp_q.push_back(8'd64); exp_q.push_back(8'd128);
    exp_q.push_back(8'd64); exp_q.push_back(8'd0);
    pulse_start();
    wait_duty0(8'd128, 50);
    pulse_stop();
    check("stop_up_phase", phase0, DOWN);
    check("stop_up_duty", duty0, 128);
    wait_done(100);
    check("stop_up_cycles", cycles0, 1);
    check("sb_empty", exp_q.size(), 0);

    // start while busy must not disturb the prescaler
    push_seq64();
    pulse_start();
    @(negedge clk);
    pulse_start();
    check("restart_phase", phase0, UP);
    n = 3;
    while (duty0 === 8'd0 && n < 20) begin @(negedge clk); n++; end
    check("busy_start_latency", n, 4);
    wait_done(200);
    check("busy_start_cycles", cycles0, 2);
    check("sb_empty", exp_q.size(), 0);

    // asynchronous reset in HOLD_HI, then a clean restart
    do_reset();
    push_seq64();
    pulse_start();
    wait_duty0(8'd255, 100);
    check("hold_hi_phase", phase0, HOLD_HI);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_duty", duty0, 0);
    check("async_phase", phase0, 0);
    check("async_busy", busy0, 0);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    #1 mon_en = 1'b1;
    check("post_rst_cycles", cycles0, 0);
    push_seq64();
    pulse_start();
    wait_done(200);
    check("restart_cycles", cycles0, 1);
    check("sb_empty", exp_q.size(), 0);

    // STEP=1 and STEP=255 saturation / floor
    do_reset();
    mon_en = 1'b0;
    pulse_start();
    prev1 = 0; bad = 0; n255 = -1; ndone1 = -1; up = 1'b1;
    for (int t = 1; t <= 2200; t++) begin
      @(negedge clk);
      if (t == 3)  check("s255_pre", duty2, 0);
      if (t == 4)  check("s255_sat", duty2, 255);
      if (t == 12) check("s255_hold_phase", phase2, DOWN);
      if (t == 16) begin
        check("s255_floor", duty2, 0);
        check("s255_done", done2, 1);
      end
      if (int'(duty1) != prev1) begin
        if (up ? (int'(duty1) != prev1 + 1) : (int'(duty1) != prev1 - 1)) bad++;
        if (up && duty1 == 8'd255) begin n255 = t; up = 1'b0; end
        prev1 = int'(duty1);
      end
      if (done1 === 1'b1) begin ndone1 = t; break; end
    end
    check("s1_steps", bad, 0);
    check("s1_ramp_up_len", n255, 1020);
    check("s1_done_time", ndone1, 2048);
    check("s1_floor", duty1, 0);
    check("s1_cycles", cycles1, 1);
    check("s255_cycles", cycles2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/led_fade_sequencer.md
# led_fade_sequencer

Brightness sequencer that drives the 8-bit duty input (`bin`) of the LED PWM/display controller. It produces a breathing pattern: ramp up, hold at full, ramp down, hold at off, repeated. Each step is paced by an internal tick prescaler. It sits between the user controls (start, stop and loop inputs) and the LED control datapath, and reports its phase and a completed-cycle count for display on the seven-segment outputs.

## Interface
- `TICK_DIV`, default 1000: clk cycles per step tick (1 ms at 1 MHz); minimum 2.
- `STEP`, default 1: duty increment/decrement per tick, 1..255.
- `HOLD_TICKS`, default 250: ticks spent in each hold state, minimum 1.

- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  single-cycle request to begin a sequence; honoured only in IDLE.
- `stop`  in  1  single-cycle request to finish gracefully.
- `loop`  in  1  level; when 1 the sequence repeats, when 0 it ends after one fade.
- `duty`  out  8  registered brightness, connects to the LED controller `bin`.
- `busy`  out  1  1 in every state except IDLE.
- `phase`  out  3  current state encoding.
- `done`  out  1  one-cycle pulse on the cycle the block re-enters IDLE.
- `cycles`  out  8  completed up/down fades, wraps 255 -> 0.

## Operation
- States: IDLE=0, UP=1, HOLD_HI=2, DOWN=3, HOLD_LO=4. Codes 5..7 are illegal and recover to IDLE with `duty`=0.
- Prescaler `pcnt` counts 0..TICK_DIV-1 while busy. `tick` is high combinationally when `pcnt`==TICK_DIV-1. `pcnt` is held at 0 in IDLE.
- IDLE: `duty`=0. `start`=1 and `stop`=0 moves to UP and clears `pcnt`.
- UP: on `tick`, `duty` = min(`duty`+STEP, 255), saturating, computed in 9 bits. When the updated value is 255, go to HOLD_HI and clear the hold counter.
- HOLD_HI: on `tick`, the hold counter increments. On the tick where it equals HOLD_TICKS-1, go to DOWN.
- DOWN: on `tick`, `duty` = max(`duty`-STEP, 0), floored at 0. When the updated value is 0:
  - `cycles` increments.
  - If `loop`=1 and no stop is pending, go to HOLD_LO.
  - Otherwise go to IDLE and pulse `done`.
- HOLD_LO: works like HOLD_HI, then returns to UP.
- `stop` in any busy state sets `stop_pend`.
  - In UP, HOLD_HI or HOLD_LO it forces an immediate transition to DOWN on the next edge. `duty` is kept and the hold counter is cleared.
  - DOWN then runs to 0 and ends in IDLE.
  - `stop_pend` clears on entry to IDLE.
- `start` while busy is ignored. If `start` and `stop` are asserted in the same cycle, `stop` wins; in IDLE both are then ignored.
- `loop` is sampled only at the DOWN-reaches-0 decision.
- Stop in HOLD_LO with `duty`=0: go to DOWN. The next tick keeps 0, then the block goes to IDLE with `done`, and `cycles` is **not** incremented again.

## Timing
- Reset values: `duty`=0, `busy`=0, `phase`=0, `done`=0, `cycles`=0. Internal `pcnt`, hold counter and `stop_pend` are also 0.
- Reset mid-sequence drops `duty` to 0 asynchronously.
- Start latency: with `start` sampled at edge E0, `phase`=UP and `busy`=1 after E0. `duty` first changes after edge E0+TICK_DIV.
- `duty` changes only on edges where `tick` was high, so there is exactly one update per TICK_DIV cycles.
- Ramp length is ceil(255/STEP) ticks. Each hold lasts HOLD_TICKS ticks.
- `done` is high for exactly the one cycle in which `phase` first reads IDLE.
- `cycles` updates on the same edge as the final `duty`=0 update.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `led_seq_pkg` holds:
  - the state encodings IDLE/UP/HOLD_HI/DOWN/HOLD_LO (3 bits);
  - `DUTY_MAX`=8'd255 and `DUTY_MIN`=8'd0.
- Sub-module `tick_prescaler`:
  - parameter `TICK_DIV`;
  - ports `clk`, `rst`, `en`, `clr`, `tick`;
  - `clr` has priority over `en`.
- The top level contains the FSM, the duty register with saturating arithmetic, the hold counter (width clog2(HOLD_TICKS)+1), `stop_pend` and `cycles`.

## Test plan
Bench parameters: TICK_DIV=4, STEP=64, HOLD_TICKS=2, clk 1 MHz.
- Reset, then `start` with `loop`=0 -> `duty` goes 64,128,192,255, holds 2 ticks, then 191,127,63,0. Next it goes to IDLE with a one-cycle `done` and `cycles`=1. The first `duty` change is 4 cycles after the start edge.
- `loop`=1 for 3 fades -> HOLD_LO is visited between fades, `cycles` reads 1,2,3 at each 0, `busy` stays 1 and `done` never pulses.
- `stop` in UP at `duty`=128 -> next edge `phase`=DOWN, then `duty` 64,0, then IDLE with `done`, `cycles`=1.
- `start`+`stop` same cycle in IDLE -> stays IDLE, `duty`=0. `start` during UP -> no effect on `duty`/`pcnt`.
- Async `rst` during HOLD_HI -> `duty`=0, `phase`=0 immediately without waiting for an edge. A subsequent `start` restarts from 0.
- STEP=1 and STEP=255 runs -> saturation at 255 and floor at 0 exact, no wrap. Ramp lengths are 255 ticks and 1 tick respectively.
